// File: rtl/cv32e40p_pipe_stage_ft_pkg.sv
// Shared definitions for the fault-tolerant pipeline stage.
//   occ_e : stage occupancy (EMPTY / ONE / FULL)
//   maj3  : 2-of-3 majority vote of single bits, applied bitwise by callers
// Build option: CV32E40P_PIPE_TMR_EN (used by the stage and entry files).
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/cv32e40p_pipe_stage_ft_if.sv
// Handshake bundle of cv32e40p_pipe_stage_ft.
//   master : upstream/downstream/control side that drives the stage
//   slave  : the stage itself
// Signals: flush_i, in_valid_i/in_ready_o/in_data_i/in_ctrl_i,
//          out_valid_o/out_ready_i/out_data_o/out_ctrl_o,
//          upd_en_i/upd_mask_i/upd_data_i, tmr_err_o.
interface cv32e40p_pipe_stage_ft_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic [CTRL_W-1:0] in_ctrl_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic              upd_en_i;
  logic [DATA_W-1:0] upd_mask_i;
  logic [DATA_W-1:0] upd_data_i;
  logic              tmr_err_o;

  modport master (
    output flush_i, in_valid_i, in_data_i, in_ctrl_i, out_ready_i,
           upd_en_i, upd_mask_i, upd_data_i,
    input  in_ready_o, out_valid_o, out_data_o, out_ctrl_o, tmr_err_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_data_i, in_ctrl_i, out_ready_i,
           upd_en_i, upd_mask_i, upd_data_i,
    output in_ready_o, out_valid_o, out_data_o, out_ctrl_o, tmr_err_o
  );
endinterface

// File: rtl/cv32e40p_pipe_stage_ft_entry.sv
// cv32e40p_pipe_entry_ft: one payload+control register of the stage.
// Ports: clk, rst_n, load_en/load_data/load_ctrl (new entry),
//        upd_en/upd_mask/upd_data (masked in-place payload rewrite),
//        data/ctrl (stored or voted value), err (copies disagree).
// Build option: CV32E40P_PIPE_TMR_EN triplicates storage; every cycle the
// voted value (or the new value) is written back to all copies, so a single
// upset is visible on err for one cycle only.
module cv32e40p_pipe_entry_ft
  import cv32e40p_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic              upd_en,
  input  logic [DATA_W-1:0] upd_mask,
  input  logic [DATA_W-1:0] upd_data,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl,
  output logic              err
);

  logic [DATA_W-1:0] data_v, data_n;
  logic [CTRL_W-1:0] ctrl_v, ctrl_n;

  // load wins over update; the stage never requests both for one entry
  always_comb begin
    data_n = data_v;
    ctrl_n = ctrl_v;
    if (load_en) begin
      data_n = load_data;
      ctrl_n = load_ctrl;
    end else if (upd_en) begin
      data_n = (data_v & ~upd_mask) | (upd_data & upd_mask);
    end
  end

`ifdef CV32E40P_PIPE_TMR_EN
  logic [2:0][DATA_W-1:0] data_q;
  logic [2:0][CTRL_W-1:0] ctrl_q;

  always_comb begin
    for (int i = 0; i < DATA_W; i++) data_v[i] = maj3(data_q[0][i], data_q[1][i], data_q[2][i]);
    for (int i = 0; i < CTRL_W; i++) ctrl_v[i] = maj3(ctrl_q[0][i], ctrl_q[1][i], ctrl_q[2][i]);
  end

  assign err = (data_q[0] != data_q[1]) | (data_q[0] != data_q[2]) |
               (ctrl_q[0] != ctrl_q[1]) | (ctrl_q[0] != ctrl_q[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else begin
      data_q <= {3{data_n}};
      ctrl_q <= {3{ctrl_n}};
    end
  end
`else
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  assign data_v = data_q;
  assign ctrl_v = ctrl_q;
  assign err    = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else begin
      data_q <= data_n;
      ctrl_q <= ctrl_n;
    end
  end
`endif

  assign data = data_v;
  assign ctrl = ctrl_v;

endmodule

// File: rtl/cv32e40p_pipe_stage_ft.sv
// cv32e40p_pipe_stage_ft: two-entry (head + skid) pipeline stage with a
// registered in_ready, masked replay update of a stalled head, flush, and
// optional triple modular redundancy.
// Ports: clk, rst_n (async, active-low), bus (cv32e40p_pipe_stage_ft_if.slave).
// Build option: CV32E40P_PIPE_TMR_EN triplicates entries, occupancy state and
// the in_ready register; tmr_err_o flags any disagreement between copies.
module cv32e40p_pipe_stage_ft
  import cv32e40p_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                CTRL_W    = 8,
  parameter logic [CTRL_W-1:0] CTRL_IDLE = '0
) (
  input logic                     clk,
  input logic                     rst_n,
  cv32e40p_pipe_stage_ft_if.slave bus
);

  occ_e              state_v, state_n;
  logic              rdy_v, rdy_n;
  logic              core_err, head_err, skid_err;
  logic              accept, pop;
  logic              head_load, head_from_skid, skid_load, head_upd;
  logic [DATA_W-1:0] head_data, skid_data;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl;

  assign accept = bus.in_valid_i & rdy_v;
  assign pop    = (state_v != OCC_EMPTY) & bus.out_ready_i;
  assign rdy_n  = (state_n != OCC_FULL);

  // state / ready register
`ifdef CV32E40P_PIPE_TMR_EN
  logic [2:0][1:0] state_q;
  logic [2:0]      rdy_q;
  logic [1:0]      state_vote;

  always_comb begin
    for (int i = 0; i < 2; i++) state_vote[i] = maj3(state_q[0][i], state_q[1][i], state_q[2][i]);
  end
  assign state_v  = occ_e'(state_vote);
  assign rdy_v    = maj3(rdy_q[0], rdy_q[1], rdy_q[2]);
  assign core_err = (state_q[0] != state_q[1]) | (state_q[0] != state_q[2]) |
                    (rdy_q[0] != rdy_q[1]) | (rdy_q[0] != rdy_q[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= {3{OCC_EMPTY}};
      rdy_q   <= '1;
    end else begin
      state_q <= {3{state_n}};
      rdy_q   <= {3{rdy_n}};
    end
  end
`else
  occ_e state_q;
  logic rdy_q;

  assign state_v  = state_q;
  assign rdy_v    = rdy_q;
  assign core_err = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_n;
      rdy_q   <= rdy_n;
    end
  end
`endif

  // next-state
  always_comb begin
    state_n = state_v;
    if (bus.flush_i) begin
      state_n = OCC_EMPTY;
    end else begin
      case (state_v)
        OCC_EMPTY: if (accept) state_n = OCC_ONE;
        OCC_ONE: begin
          if (accept && !pop)      state_n = OCC_FULL;
          else if (pop && !accept) state_n = OCC_EMPTY;
        end
        OCC_FULL:  if (pop) state_n = OCC_ONE;
        default:   state_n = OCC_EMPTY;   // unreachable encoding after a bad vote
      endcase
    end
  end

  // outputs and entry controls; flush blocks every storage write so the
  // head keeps the last payload visible while empty
  always_comb begin
    head_load      = 1'b0;
    skid_load      = 1'b0;
    head_upd       = 1'b0;
    head_from_skid = (state_v == OCC_FULL);
    if (!bus.flush_i) begin
      head_load = ((state_v == OCC_EMPTY) && accept) ||
                  ((state_v == OCC_ONE) && pop && accept) ||
                  ((state_v == OCC_FULL) && pop);
      skid_load = (state_v == OCC_ONE) && accept && !pop;
      head_upd  = (state_v != OCC_EMPTY) && !bus.out_ready_i && bus.upd_en_i;
    end
    bus.in_ready_o  = rdy_v;
    bus.out_valid_o = (state_v != OCC_EMPTY);
    bus.out_data_o  = head_data;
    bus.out_ctrl_o  = (state_v != OCC_EMPTY) ? head_ctrl : CTRL_IDLE;
    bus.tmr_err_o   = core_err | head_err | skid_err;
  end

  cv32e40p_pipe_entry_ft #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_head (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (head_load),
    .load_data (head_from_skid ? skid_data : bus.in_data_i),
    .load_ctrl (head_from_skid ? skid_ctrl : bus.in_ctrl_i),
    .upd_en    (head_upd),
    .upd_mask  (bus.upd_mask_i),
    .upd_data  (bus.upd_data_i),
    .data      (head_data),
    .ctrl      (head_ctrl),
    .err       (head_err)
  );

  cv32e40p_pipe_entry_ft #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (skid_load),
    .load_data (bus.in_data_i),
    .load_ctrl (bus.in_ctrl_i),
    .upd_en    (1'b0),
    .upd_mask  ({DATA_W{1'b0}}),
    .upd_data  ({DATA_W{1'b0}}),
    .data      (skid_data),
    .ctrl      (skid_ctrl),
    .err       (skid_err)
  );

endmodule
